bsnn_lif_param: RTL and testbench

Parametrised binary-weight leaky integrate-and-fire neuron for the BSNN datapath. It integrates N_IN binary spikes weighted by signed binary weights (+1/-1) into a saturating signed membrane. It applies a periodic leak toward zero, fires when the membrane reaches a runtime threshold, and optionally enforces a refractory period. One instance per neuron sits between the spike crossbar and the next layer's spike bus, advancing one timestep per `in_valid` strobe.

---
 rtl/bsnn_pkg.sv | 28 ++
 rtl/bsnn_lif_param_if.sv | 19 +
 rtl/bsnn_wsum.sv | 25 ++
 rtl/bsnn_lif_param.sv | 79 +++++++
 tb/tb_bsnn_lif_param.sv | 139 +++++++++++++
 5 files changed

// File: rtl/bsnn_pkg.sv
// Shared BSNN definitions: binary weight encoding, saturating add and leak-toward-zero helpers.
package bsnn_pkg;

  localparam logic W_POS = 1'b1;
  localparam logic W_NEG = 1'b0;

  // Signed add clamped to the range of a w-bit two's complement value (w <= 64).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [64:0] s, hi, lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[63:0];
  endfunction

  // Move v toward zero by step, stopping at zero rather than crossing it.
  function automatic logic signed [63:0] leak_to_zero(input logic signed [63:0] v,
                                                      input logic signed [63:0] step);
    if (v > step)       return v - step;
    else if (v < -step) return v + step;
    else                return '0;
  endfunction

endpackage

// File: rtl/bsnn_lif_param_if.sv
// Timestep bus between the spike crossbar and one LIF neuron.
interface bsnn_lif_param_if #(
  parameter int N_IN  = 4,
  parameter int MEM_W = 8
);
  logic                    in_valid;
  logic [N_IN-1:0]         spike_in;
  logic [N_IN-1:0]         weight;
  logic signed [MEM_W-1:0] threshold;
  logic                    out_valid;
  logic                    spike_out;
  logic signed [MEM_W-1:0] mem_out;
  logic                    refrac_busy;

  modport master (output in_valid, spike_in, weight, threshold,
                  input  out_valid, spike_out, mem_out, refrac_busy);
  modport slave  (input  in_valid, spike_in, weight, threshold,
                  output out_valid, spike_out, mem_out, refrac_busy);
endinterface

// File: rtl/bsnn_wsum.sv
// Combinational signed weighted popcount of binary spikes with +1/-1 weights.
module bsnn_wsum
  import bsnn_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int CW  = $clog2(N_IN + 1)
)(
  input  logic [N_IN-1:0]   spike_in,
  input  logic [N_IN-1:0]   weight,
  output logic signed [CW:0] wsum
);
  logic [CW-1:0] pos, neg;

  always_comb begin
    pos = '0;
    neg = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        if (weight[i] == W_POS) pos = pos + CW'(1);
        else                    neg = neg + CW'(1);
      end
    end
    wsum = $signed({1'b0, pos}) - $signed({1'b0, neg});
  end
endmodule

// File: rtl/bsnn_lif_param.sv
// Binary-weight leaky integrate-and-fire neuron, one timestep per in_valid strobe.
// Refractory period is built only when BSNN_LIF_REFRAC_EN is defined.
module bsnn_lif_param
  import bsnn_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int MEM_W        = 8,
  parameter int LEAK_PERIOD  = 4,
  parameter int LEAK_STEP    = 1,
  parameter int REFRAC_STEPS = 2
)(
  input logic             CLK,
  input logic             nRST,
  bsnn_lif_param_if.slave bus
);
  localparam int WS_W = $clog2(N_IN + 1) + 1;
  localparam int LC_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

  if (N_IN < 1 || N_IN > 64 || MEM_W < 2 || MEM_W > 64 || LEAK_PERIOD < 0 ||
      LEAK_STEP < 0 || REFRAC_STEPS < 0) begin : g_bad_param
    $error("bsnn_lif_param: parameter out of range");
  end

  logic signed [WS_W-1:0]  wsum;
  logic signed [MEM_W-1:0] mem, mem_i, mem_l;
  logic [LC_W-1:0]         leak_cnt, leak_cnt_nxt;
  logic                    leak_tick, fire, refrac, out_valid_q, spike_q;

  bsnn_wsum #(.N_IN(N_IN)) u_wsum (
    .spike_in (bus.spike_in),
    .weight   (bus.weight),
    .wsum     (wsum)
  );

  always_comb begin
    leak_tick    = (LEAK_PERIOD != 0) && (leak_cnt == LC_W'(LEAK_PERIOD - 1));
    leak_cnt_nxt = (LEAK_PERIOD == 0 || leak_tick) ? '0 : leak_cnt + 1'b1;
    mem_i        = MEM_W'(sat_add(64'(mem), 64'(wsum), MEM_W));
    mem_l        = leak_tick ? MEM_W'(leak_to_zero(64'(mem_i), 64'(LEAK_STEP))) : mem_i;
    fire         = !refrac && (mem_l >= bus.threshold);
  end

  // Refractory steps still advance the leak counter but leave the membrane pinned at 0.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem         <= '0;
      leak_cnt    <= '0;
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
    end else if (bus.in_valid) begin
      leak_cnt    <= leak_cnt_nxt;
      out_valid_q <= 1'b1;
      spike_q     <= fire;
      mem         <= (refrac || fire) ? '0 : mem_l;
    end else begin
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
    end
  end

`ifdef BSNN_LIF_REFRAC_EN
  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  logic [RC_W-1:0] refrac_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST)             refrac_cnt <= '0;
    else if (bus.in_valid) refrac_cnt <= refrac ? refrac_cnt - 1'b1
                                                : (fire ? RC_W'(REFRAC_STEPS) : '0);
  end
  assign refrac = (refrac_cnt != '0);
`else
  assign refrac = 1'b0;
`endif

  assign bus.out_valid   = out_valid_q;
  assign bus.spike_out   = spike_q;
  assign bus.mem_out     = mem;
  assign bus.refrac_busy = refrac;
endmodule

// File: tb/tb_bsnn_lif_param.sv
// Directed bench for bsnn_lif_param: table-driven main vectors plus saturation and leak sequences.
module tb_bsnn_lif_param;
  logic CLK = 1'b0;
  logic nRST, nRST_l;
  always #5 CLK = ~CLK;

`ifdef BSNN_LIF_REFRAC_EN
  localparam bit REN = 1'b1;
`else
  localparam bit REN = 1'b0;
`endif

  bsnn_lif_param_if #(.N_IN(4), .MEM_W(8)) bif ();
  bsnn_lif_param_if #(.N_IN(4), .MEM_W(8)) lif ();

  bsnn_lif_param #(.N_IN(4), .MEM_W(8), .LEAK_PERIOD(0), .LEAK_STEP(1), .REFRAC_STEPS(2))
    dut (.CLK(CLK), .nRST(nRST), .bus(bif));
  bsnn_lif_param #(.N_IN(4), .MEM_W(8), .LEAK_PERIOD(4), .LEAK_STEP(1), .REFRAC_STEPS(2))
    dut_leak (.CLK(CLK), .nRST(nRST_l), .bus(lif));

  typedef struct {
    logic              rst, vld;
    logic [3:0]        spk, wgt;
    logic signed [7:0] thr;
    logic              ov, so;
    logic signed [7:0] mem;
    logic              busy;
    string             name;
  } vec_t;

  vec_t tv[$];
  int n_tests = 0, n_fail = 0;

  function automatic void add(input string nm, input logic rst, vld, input logic [3:0] spk, wgt,
                              input logic signed [7:0] thr, input logic ov, so,
                              input logic signed [7:0] mem, input logic busy);
    vec_t v;
    v.name = nm; v.rst = rst; v.vld = vld; v.spk = spk; v.wgt = wgt; v.thr = thr;
    v.ov = ov; v.so = so; v.mem = mem; v.busy = busy;
    tv.push_back(v);
  endfunction

  task automatic check(input string nm, input logic ov, so, input logic signed [7:0] mem,
                       input logic busy, input logic e_ov, e_so, input logic signed [7:0] e_mem,
                       input logic e_busy);
    n_tests++;
    if ({ov, so, mem, busy} !== {e_ov, e_so, e_mem, e_busy}) begin
      n_fail++;
      $display("FAIL %s: got ov=%0b so=%0b mem=%0d busy=%0b, want ov=%0b so=%0b mem=%0d busy=%0b",
               nm, ov, so, mem, busy, e_ov, e_so, e_mem, e_busy);
    end
  endtask

  task automatic step_main(input logic rst, vld, input logic [3:0] spk, wgt,
                           input logic signed [7:0] thr);
    nRST = !rst; bif.in_valid = vld; bif.spike_in = spk; bif.weight = wgt; bif.threshold = thr;
    @(posedge CLK); #1;
  endtask

  task automatic step_leak(input logic rst, vld, input logic [3:0] spk, wgt);
    nRST_l = !rst; lif.in_valid = vld; lif.spike_in = spk; lif.weight = wgt; lif.threshold = 8'sd100;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic signed [7:0] lexp [10];
    logic signed [7:0] e;
    int k;
    nRST = 1'b0; nRST_l = 1'b0;
    bif.in_valid = 1'b0; bif.spike_in = '0; bif.weight = '0; bif.threshold = 8'sd3;
    lif.in_valid = 1'b0; lif.spike_in = '0; lif.weight = '0; lif.threshold = 8'sd100;

    //   name        rst vld spk      wgt      thr      ov so    mem busy
    add("reset0",     1, 1, 4'b1010, 4'b0110, 8'sd3,    0, 0,    0, 0);
    add("reset1",     1, 1, 4'b0101, 4'b1100, 8'sd3,    0, 0,    0, 0);
    add("fire",       0, 1, 4'b1111, 4'b1111, 8'sd3,    1, 1,    0, REN);
    add("refrac1",    0, 1, 4'b1111, 4'b1111, 8'sd3,    1, !REN, 0, REN);
    add("refrac2",    0, 1, 4'b1111, 4'b1111, 8'sd3,    1, !REN, 0, 0);
    add("refire",     0, 1, 4'b1111, 4'b1111, 8'sd3,    1, 1,    0, REN);
    add("idle_hold",  0, 0, 4'b1111, 4'b1111, 8'sd3,    0, 0,    0, REN);
    add("reset2",     1, 0, 4'b0000, 4'b0000, 8'sd3,    0, 0,    0, 0);
    add("wsum_zero",  0, 1, 4'b1111, 4'b0011, 8'sd3,    1, 0,    0, 0);
    add("wsum_plus1", 0, 1, 4'b0111, 4'b0101, 8'sd3,    1, 0,    1, 0);
    add("thr_equal",  0, 1, 4'b0011, 4'b0011, 8'sd3,    1, 1,    0, REN);
    add("reset3",     1, 0, 4'b0000, 4'b0000, 8'sd3,    0, 0,    0, 0);
    add("minthr0",    0, 1, 4'b0000, 4'b1111, -8'sd128, 1, 1,    0, REN);
    add("minthr1",    0, 1, 4'b0000, 4'b1111, -8'sd128, 1, !REN, 0, REN);
    add("minthr2",    0, 1, 4'b0000, 4'b1111, -8'sd128, 1, !REN, 0, 0);
    add("minthr3",    0, 1, 4'b0000, 4'b1111, -8'sd128, 1, 1,    0, REN);
    add("reset4",     1, 0, 4'b0000, 4'b0000, 8'sd3,    0, 0,    0, 0);
    add("load2",      0, 1, 4'b0011, 4'b1111, 8'sd3,    1, 0,    2, 0);
    add("rst_on_fire",1, 1, 4'b1111, 4'b1111, 8'sd3,    0, 0,    0, 0);
    add("post_rst",   0, 1, 4'b0001, 4'b1111, 8'sd3,    1, 0,    1, 0);
    add("post_fire",  0, 1, 4'b1111, 4'b1111, 8'sd3,    1, 1,    0, REN);

    for (int i = 0; i < tv.size(); i++) begin
      step_main(tv[i].rst, tv[i].vld, tv[i].spk, tv[i].wgt, tv[i].thr);
      check(tv[i].name, bif.out_valid, bif.spike_out, bif.mem_out, bif.refrac_busy,
            tv[i].ov, tv[i].so, tv[i].mem, tv[i].busy);
    end

    // Negative saturation: -4 per step, pinned at -128 from step 32 on.
    step_main(1, 0, 4'b0000, 4'b0000, 8'sd3);
    for (int s = 1; s <= 40; s++) begin
      step_main(0, 1, 4'b1111, 4'b0000, 8'sd3);
      e = (s >= 32) ? -8'sd128 : 8'(-4 * s);
      check($sformatf("neg_sat%0d", s), bif.out_valid, bif.spike_out, bif.mem_out,
            bif.refrac_busy, 1, 0, e, 0);
    end

    // Positive saturation: +4 per step up to 124, then clamps to 127 and fires at thr=127.
    step_main(1, 0, 4'b0000, 4'b0000, 8'sd127);
    for (int s = 1; s <= 32; s++) begin
      step_main(0, 1, 4'b1111, 4'b1111, 8'sd127);
      if (s == 31 || s == 32)
        check($sformatf("pos_sat%0d", s), bif.out_valid, bif.spike_out, bif.mem_out,
              bif.refrac_busy, 1, s == 32, (s == 32) ? 8'sd0 : 8'sd124, (s == 32) && REN);
    end

    // Leak every 4th valid step (the load step counts as the first), with one idle gap.
    lexp = '{8'sd2, 8'sd2, 8'sd2, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd0, 8'sd0};
    for (int sg = 0; sg < 2; sg++) begin
      step_leak(1, 0, 4'b0000, 4'b0000);
      step_leak(0, 1, 4'b0011, (sg == 0) ? 4'b1111 : 4'b0000);
      check($sformatf("leak_load_s%0d", sg), lif.out_valid, lif.spike_out, lif.mem_out,
            lif.refrac_busy, 1, 0, (sg == 0) ? 8'sd2 : -8'sd2, 0);
      for (int z = 0; z < 10; z++) begin
        k = (z == 1) ? 0 : 1;
        step_leak(0, k[0], 4'b0000, 4'b1111);
        e = (sg == 0) ? lexp[z] : -lexp[z];
        check($sformatf("leak_s%0d_z%0d", sg, z), lif.out_valid, lif.spike_out, lif.mem_out,
              lif.refrac_busy, k[0], 0, e, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
